btb_update_ctrl: RTL and testbench
==================================

// Module: btb_update_ctrl
// PURPOSE
//  Sequences all writes into the direct-mapped BTB from the EX stage.
//  Buffers resolved taken-branch updates in a small FIFO and drains them one per cycle onto the BTB write port.
//  Runs a fence sweep that invalidates every BTB entry, one index per cycle.
//  Sits between EX branch resolution and the BTB update/invalidate ports.
// PARAMETERS
//  DEPTH    4  update FIFO depth; power of two, >=2
//  ENTRIES  4  BTB entry count; power of two; IDX_W = $clog2(ENTRIES)
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, asynchronous, active-high
//  req_valid       in   1      EX has a resolved taken branch/jal/jalr update
//  req_pc          in   32     PC of that branch
//  req_target      in   32     resolved target
//  req_ready       out  1      update accepted this cycle when req_valid&&req_ready
//  fence_req       in   1      request full BTB invalidate (level or pulse)
//  fence_done      out  1      one-cycle pulse: sweep complete
//  btb_upd_en      out  1      BTB write strobe
//  btb_upd_pc      out  32     BTB write PC
//  btb_upd_target  out  32     BTB write target
//  btb_inv_en      out  1      BTB invalidate strobe (clears valid[btb_inv_idx])
//  btb_inv_idx     out  IDX_W  index being invalidated
//  busy            out  1      FIFO non-empty or state != IDLE
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FIFO empty; state IDLE; sweep counter 0.
//   - Reset mid-sweep or mid-drain abandons the operation; the FIFO contents are lost.
//  States: IDLE, SWEEP, DONE.
//  IDLE:
//   - req_ready = !full. A write and a pop may occur in the same cycle.
//   - When full, pushes are refused even if a pop occurs that cycle.
//   - If the FIFO is non-empty, pop the head each cycle and drive btb_upd_* registered, the following cycle.
//   - Minimum latency: a request accepted at cycle N with the FIFO empty gives btb_upd_en=1 at cycle N+1 with that pc/target.
//   - A request that finds the FIFO non-empty leaves in FIFO order.
//   - When the FIFO is empty, btb_upd_en=0 and btb_upd_pc/btb_upd_target hold their last values.
//  IDLE & fence_req -> SWEEP:
//   - Flush the FIFO; pending updates are discarded (superseded by the invalidate).
//   - A req_valid in the same cycle is not accepted: req_ready=0 that cycle.
//   - btb_upd_en is 0 from the following cycle.
//  SWEEP:
//   - req_ready=0.
//   - btb_inv_en=1, btb_inv_idx=0..ENTRIES-1 on consecutive cycles, starting the cycle after fence_req.
//   - fence_req is ignored.
//   - After idx ENTRIES-1 -> DONE.
//  DONE:
//   - One cycle: fence_done=1, btb_inv_en=0, req_ready=0 -> IDLE.
//   - A fence_req still high in IDLE starts a new sweep.
//  Sweep length: ENTRIES cycles of btb_inv_en, then 1 cycle of fence_done.
//  btb_upd_en and btb_inv_en are never high together.
//  FIFO pointers: IDX($clog2(DEPTH))+1 bits; wrap naturally.
//   - full = (ptr MSBs differ) && (low bits equal).
// CONFIGURATION
//  BTB_UPD_FILTER_EN defined:
//   - An accepted request whose {pc,target} equals the last enqueued {pc,target} is acknowledged (req_ready=1) but not enqueued.
//   - The last-enqueued register is cleared by reset and by fence.
//   - An 8-bit saturating drop counter is kept, output as extra port filt_drops[7:0], reset 0.
//  BTB_UPD_FILTER_EN undefined:
//   - Every accepted request is enqueued.
//   - No filt_drops port exists.
// TESTING
//  - Reset: rst=1 mid-stream -> all outputs 0, busy=0; first req after release gives upd_en at N+1.
//  - Burst: 5 back-to-back reqs pc=0x100..0x110 (step 4), DEPTH=4 -> in-order upd; req_ready drops only when full; no loss.
//  - Fence during drain: 3 queued, fence_req -> no further upd_en; inv_idx 0,1,2,3 on 4 cycles; fence_done pulse; req_ready back to 1.
//  - Collision: req_valid and fence_req in the same cycle -> req not accepted; sweep proceeds.
//  - Filter (_EN on): same req pc=0x200,target=0x400 three times -> one btb_upd_en, filt_drops=2; after fence, the same req is enqueued again.
//  - Full + pop: FIFO full, a req held valid -> accepted the cycle after the pop frees a slot.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: buffers EX taken-branch updates and drains them onto the BTB write port.
// Also runs the fence invalidate sweep. Optional duplicate filter: define BTB_UPD_FILTER_EN.
module btb_update_ctrl #(
  parameter  int DEPTH   = 4,
  parameter  int ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      req_pc,
  input  logic [31:0]      req_target,
  output logic             req_ready,
  input  logic             fence_req,
  output logic             fence_done,
  output logic             btb_upd_en,
  output logic [31:0]      btb_upd_pc,
  output logic [31:0]      btb_upd_target,
  output logic             btb_inv_en,
  output logic [IDX_W-1:0] btb_inv_idx,
  output logic             busy
`ifdef BTB_UPD_FILTER_EN
  ,
  output logic [7:0]       filt_drops
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [63:0]      mem [DEPTH];

  logic full;
  logic empty;
  logic do_fence;
  logic accept;
  logic dup;
  logic enq;
  logic push_fifo;
  logic pop_fifo;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_fence  = (state == IDLE) && fence_req;
  assign req_ready = !rst && (state == IDLE) && !full && !fence_req;
  assign accept    = req_valid && req_ready;
  assign enq       = accept && !dup;
  // An empty FIFO is bypassed so a fresh request reaches the BTB the very next cycle.
  assign push_fifo = enq && !empty;
  assign pop_fifo  = (state == IDLE) && !fence_req && !empty;

  assign busy = !empty || (state != IDLE);

  // NOTE: the payload array has no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_fifo) mem[wr_ptr[AW-1:0]] <= {req_pc, req_target};
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (do_fence) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fifo) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fifo)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      btb_upd_en     <= 1'b0;
      btb_upd_pc     <= '0;
      btb_upd_target <= '0;
      btb_inv_en     <= 1'b0;
      btb_inv_idx    <= '0;
      fence_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fence_req) begin
            state       <= SWEEP;
            btb_upd_en  <= 1'b0;
            btb_inv_en  <= 1'b1;
            btb_inv_idx <= '0;
          end else if (!empty) begin
            btb_upd_en                   <= 1'b1;
            {btb_upd_pc, btb_upd_target} <= mem[rd_ptr[AW-1:0]];
          end else if (enq) begin
            btb_upd_en     <= 1'b1;
            btb_upd_pc     <= req_pc;
            btb_upd_target <= req_target;
          end else begin
            btb_upd_en <= 1'b0;
          end
        end
        SWEEP: begin
          if (btb_inv_idx == IDX_W'(ENTRIES - 1)) begin
            state       <= DONE;
            btb_inv_en  <= 1'b0;
            btb_inv_idx <= '0;
            fence_done  <= 1'b1;
          end else begin
            btb_inv_idx <= btb_inv_idx + IDX_W'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          fence_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BTB_UPD_FILTER_EN
  logic        last_vld;
  logic [31:0] last_pc;
  logic [31:0] last_target;

  assign dup = last_vld && (req_pc == last_pc) && (req_target == last_target);

  // The last-enqueued record is forgotten on fence, since the BTB is about to be wiped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_vld    <= 1'b0;
      last_pc     <= '0;
      last_target <= '0;
      filt_drops  <= '0;
    end else begin
      if (do_fence) begin
        last_vld <= 1'b0;
      end else if (enq) begin
        last_vld    <= 1'b1;
        last_pc     <= req_pc;
        last_target <= req_target;
      end
      if (accept && dup && filt_drops != 8'hFF) filt_drops <= filt_drops + 8'd1;
    end
  end
`else
  assign dup = 1'b0;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized self-checking bench for btb_update_ctrl against a queue-based reference model.
module tb_btb_update_ctrl;

  localparam int DEPTH   = 4;
  localparam int ENTRIES = 4;
  localparam int IDX_W   = $clog2(ENTRIES);
`ifdef BTB_UPD_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [31:0]      req_pc;
  logic [31:0]      req_target;
  logic             req_ready;
  logic             fence_req;
  logic             fence_done;
  logic             btb_upd_en;
  logic [31:0]      btb_upd_pc;
  logic [31:0]      btb_upd_target;
  logic             btb_inv_en;
  logic [IDX_W-1:0] btb_inv_idx;
  logic             busy;
`ifdef BTB_UPD_FILTER_EN
  logic [7:0]       filt_drops;
`endif

  btb_update_ctrl #(.DEPTH(DEPTH), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_pc(req_pc), .req_target(req_target), .req_ready(req_ready),
    .fence_req(fence_req), .fence_done(fence_done),
    .btb_upd_en(btb_upd_en), .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target),
    .btb_inv_en(btb_inv_en), .btb_inv_idx(btb_inv_idx), .busy(busy)
`ifdef BTB_UPD_FILTER_EN
    , .filt_drops(filt_drops)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending updates as a queue, sweep as a position counter.
  typedef struct packed {logic [31:0] pc; logic [31:0] tgt;} upd_t;
  upd_t        q[$];
  int          sweep_pos;
  bit          done_now;
  bit          m_upd_en;
  logic [31:0] m_pc, m_tgt;
  bit          m_inv_en;
  int          m_inv_idx;
  bit          m_done;
  bit          last_vld;
  upd_t        last;
  int          m_drops;

  function automatic bit m_idle();
    return sweep_pos < 0 && !done_now;
  endfunction

  task automatic model_reset();
    q.delete();
    sweep_pos = -1; done_now = 0; m_upd_en = 0; m_pc = '0; m_tgt = '0;
    m_inv_en = 0; m_inv_idx = 0; m_done = 0; last_vld = 0; last = '0; m_drops = 0;
  endtask

  task automatic model_edge(input bit v, input upd_t r, input bit f, input bit rdy);
    bit acc, dup;
    upd_t h;
    if (m_idle() && f) begin
      q.delete(); last_vld = 0; m_upd_en = 0;
      sweep_pos = 0; m_inv_en = 1; m_inv_idx = 0;
    end else if (m_idle()) begin
      acc = v && rdy;
      dup = FILT && last_vld && (last == r);
      if (acc && dup && m_drops < 255) m_drops++;
      if (acc && !dup) begin last = r; last_vld = 1; end
      if (q.size() > 0) begin
        h = q.pop_front();
        m_upd_en = 1; m_pc = h.pc; m_tgt = h.tgt;
        if (acc && !dup) q.push_back(r);
      end else if (acc && !dup) begin
        m_upd_en = 1; m_pc = r.pc; m_tgt = r.tgt;
      end else begin
        m_upd_en = 0;
      end
    end else if (sweep_pos >= 0) begin
      if (sweep_pos == ENTRIES - 1) begin
        sweep_pos = -1; m_inv_en = 0; m_inv_idx = 0; done_now = 1; m_done = 1;
      end else begin
        sweep_pos++; m_inv_idx = sweep_pos;
      end
    end else begin
      done_now = 0; m_done = 0;
    end
  endtask

  task automatic check_outputs();
    check("upd_en", btb_upd_en, m_upd_en);
    check("upd_pc", btb_upd_pc, m_pc);
    check("upd_target", btb_upd_target, m_tgt);
    check("inv_en", btb_inv_en, m_inv_en);
    check("inv_idx", btb_inv_idx, m_inv_idx);
    check("fence_done", fence_done, m_done);
    check("busy", busy, (q.size() > 0) || !m_idle());
    check("upd_inv_exclusive", btb_upd_en & btb_inv_en, 1'b0);
`ifdef BTB_UPD_FILTER_EN
    check("filt_drops", filt_drops, m_drops);
`endif
  endtask

  // One clock: apply inputs after the falling edge, check ready, check registered outputs after the rising edge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] tgt, input bit f);
    bit rdy;
    @(negedge clk);
    req_valid = v; req_pc = pc; req_target = tgt; fence_req = f;
    #1;
    rdy = m_idle() && q.size() < DEPTH && !f;
    check("req_ready", req_ready, rdy);
    @(posedge clk);
    #1;
    model_edge(v, {pc, tgt}, f, rdy);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid = 0; fence_req = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_req_ready", req_ready, 1'b0);
    check_outputs();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_pc = '0; req_target = '0; fence_req = 0;
    model_reset();
    #12;
    check_outputs();
    check("reset_req_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // First request after reset appears one cycle later.
    step(1'b1, 32'h40, 32'h80, 1'b0);
    idle_cycles(2);

    // Back-to-back burst.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
    idle_cycles(2);

    // Fence while updates are in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(4 * i), 32'h3000 + 32'(i), 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle_cycles(6);

    // Request colliding with fence is refused; fence held high through sweep restarts.
    step(1'b1, 32'h500, 32'h600, 1'b1);
    for (int i = 0; i < ENTRIES + 3; i++) step(1'b1, 32'h504, 32'h604, 1'b1);
    idle_cycles(8);

    // Repeated identical request, then fence, then the same request again.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200, 32'h400, 1'b0);
    idle_cycles(1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle_cycles(6);
    step(1'b1, 32'h200, 32'h400, 1'b0);
    idle_cycles(2);

    // Reset mid-stream and mid-sweep.
    step(1'b1, 32'h700, 32'h800, 1'b0);
    apply_reset();
    step(1'b1, 32'h704, 32'h804, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    apply_reset();
    step(1'b1, 32'h708, 32'h808, 1'b0);
    idle_cycles(1);

    // Random traffic with a small address pool so duplicates occur.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] pc;
      logic [31:0] tgt;
      bit v, f;
      pc  = 32'h2000 + 32'(4 * $urandom_range(0, 3));
      tgt = 32'h8000 + 32'(4 * $urandom_range(0, 1));
      v   = ($urandom_range(0, 99) < 70);
      f   = ($urandom_range(0, 99) < 5);
      step(v, pc, tgt, f);
      if ($urandom_range(0, 499) == 0) apply_reset();
    end
    idle_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
